// File: rtl/float_argmin_reduce.sv
// rtl/float_argmin_reduce.sv - streaming binary32 minimum reducer with argmin
module float_argmin_reduce #(
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 16,
   parameter int DELAY_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               running,
   input  logic               run,
   input  logic [DELAY_W-1:0] delay0,
   input  logic [LEN_W-1:0]   length,
   input  logic [DATA_W-1:0]  in0,
   output logic [DATA_W-1:0]  out0,
   output logic [LEN_W-1:0]   out1,
   output logic               done
);

   // Canonical quiet NaN marks "no non-NaN sample seen yet".
   localparam logic [DATA_W-1:0] EMPTY = DATA_W'(32'h7FC0_0000);

   // Field positions of the binary32 encoding.
   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int MAN_MSB  = 22;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACC  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [DELAY_W-1:0] delay_cnt;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   idx;

   logic               sample_nan;
   logic               sample_less;
   logic               out_empty;
   logic               last_sample;
   logic               len_zero;
   logic               count_down;
   logic               capture;
   logic               take;

   // Classify the incoming sample and order it against the current minimum.
   always_comb begin
      sample_nan  = (&in0[EXP_MSB:EXP_LSB]) && (|in0[MAN_MSB:0]);
      out_empty   = (out0 == EMPTY);
      sample_less = 1'b0;
      if (in0[SIGN_BIT] != out0[SIGN_BIT]) begin
         // Differing signs: the negative one is smaller, which also orders -0 below +0.
         sample_less = in0[SIGN_BIT];
      end else if (!in0[SIGN_BIT]) begin
         sample_less = (in0[EXP_MSB:0] < out0[EXP_MSB:0]);
      end else begin
         sample_less = (in0[EXP_MSB:0] > out0[EXP_MSB:0]);
      end
   end

   // Index compare against length-1 stays inside LEN_W, so the maximum length cannot wrap.
   always_comb begin
      len_zero    = (len_q == '0);
      last_sample = (idx == (len_q - LEN_W'(1)));
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: run restarts from any state, running low aborts only while busy.
   always_comb begin
      state_next = state;
      if (run) begin
         // A zero delay skips WAIT so that sample 0 lands on the edge after run.
         state_next = (delay0 == '0) ? S_ACC : S_WAIT;
      end else begin
         case (state)
            S_IDLE: state_next = S_IDLE;
            S_WAIT: begin
               if (!running) begin
                  state_next = S_IDLE;
               end else if (delay_cnt <= DELAY_W'(1)) begin
                  state_next = S_ACC;
               end
            end
            S_ACC: begin
               if (!running) begin
                  state_next = S_IDLE;
               end else if (len_zero || last_sample) begin
                  state_next = S_DONE;
               end
            end
            S_DONE: state_next = S_DONE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // Output and datapath-control decode from the current state.
   always_comb begin
      done       = (state == S_DONE);
      count_down = (state == S_WAIT) && running && !run;
      capture    = (state == S_ACC) && running && !run && !len_zero;
      take       = capture && !sample_nan && (out_empty || sample_less);
   end

   // Start-time latching and the delay countdown.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q     <= '0;
         delay_cnt <= '0;
      end else if (run) begin
         len_q     <= length;
         delay_cnt <= delay0;
      end else if (count_down) begin
         delay_cnt <= delay_cnt - DELAY_W'(1);
      end
   end

   // Sample index: cleared at start, advances on every captured sample, NaN or not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
      end else if (run) begin
         idx <= '0;
      end else if (capture && !last_sample) begin
         idx <= idx + LEN_W'(1);
      end
   end

   // Running minimum and its index; abort leaves the partial result in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out0 <= '0;
         out1 <= '0;
      end else if (run) begin
         out0 <= EMPTY;
         out1 <= '1;
      end else if (take) begin
         out0 <= in0;
         out1 <= idx;
      end
   end

endmodule

// File: tb/tb_float_argmin_reduce.sv
// tb/tb_float_argmin_reduce.sv - scoreboard bench for float_argmin_reduce
module tb_float_argmin_reduce;

   localparam logic [31:0] EMPTY = 32'h7FC0_0000;
   localparam logic [31:0] JUNK  = 32'hFF7F_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        running;
   logic        run;
   logic [15:0] delay0;
   logic [15:0] length;
   logic [31:0] in0;
   logic [31:0] out0;
   logic [15:0] out1;
   logic        done;

   typedef struct {
      logic [31:0] v;
      logic [15:0] i;
      int          edge_n;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] stim[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   float_argmin_reduce #(.DATA_W(32), .LEN_W(16), .DELAY_W(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .running (running),
      .run     (run),
      .delay0  (delay0),
      .length  (length),
      .in0     (in0),
      .out0    (out0),
      .out1    (out1),
      .done    (done)
   );

   // Map a binary32 pattern onto an unsigned key whose order is the float order.
   function automatic logic [31:0] order_key(input logic [31:0] x);
      return x[31] ? ~x : (x | 32'h8000_0000);
   endfunction

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Reference result over the first n entries of stim.
   function automatic exp_t model(input int n, input int dly, input int len);
      exp_t e;
      logic have;
      e.v = EMPTY;
      e.i = 16'hFFFF;
      have = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (!is_nan(stim[k]) && (!have || order_key(stim[k]) < order_key(e.v))) begin
            e.v = stim[k];
            e.i = k[15:0];
            have = 1'b1;
         end
      end
      e.edge_n = (len == 0) ? dly + 1 : dly + len;
      return e;
   endfunction

   // Full reduction: push expectation, drive stream, report edge (after E0) where done rose.
   task automatic do_run(input int dly, input int len, output int got_edge);
      exp_q.push_back(model(len, dly, len));
      @(negedge clk);
      run = 1'b1; delay0 = dly[15:0]; length = len[15:0]; in0 = JUNK;
      @(negedge clk);
      run = 1'b0;
      got_edge = -1;
      for (int n = 1; n <= dly + len + 8; n++) begin
         int k;
         k = n - dly - 1;
         in0 = (k >= 0 && k < len) ? stim[k] : JUNK;
         @(negedge clk);
         if (done) begin
            got_edge = n;
            break;
         end
      end
      in0 = JUNK;
   endtask

   // Start a reduction and feed only nfeed samples, stopping just after the last capture.
   task automatic start_partial(input int dly, input int len, input int nfeed);
      @(negedge clk);
      run = 1'b1; delay0 = dly[15:0]; length = len[15:0]; in0 = JUNK;
      @(negedge clk);
      run = 1'b0;
      for (int n = 1; n <= dly + nfeed; n++) begin
         int k;
         k = n - dly - 1;
         in0 = (k >= 0) ? stim[k] : JUNK;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; running = 1'b1; run = 1'b0; delay0 = '0; length = '0; in0 = JUNK;
      repeat (2) @(negedge clk);
      checks++; if (out0 !== 32'h0) begin errors++; $display("FAIL reset out0: got %h want %h", out0, 32'h0); end
      checks++; if (out1 !== 16'h0) begin errors++; $display("FAIL reset out1: got %h want %h", out1, 16'h0); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int g; exp_t e;
      stim = '{32'h4040_0000, 32'hBFC0_0000, 32'h4000_0000, 32'hBFC0_0000};
      do_run(0, 4, g);
      e = exp_q.pop_front();
      checks++; if (g !== e.edge_n) begin errors++; $display("FAIL basic done_edge: got %0d want %0d", g, e.edge_n); end
      checks++; if (out0 !== e.v) begin errors++; $display("FAIL basic out0: got %h want %h", out0, e.v); end
      checks++; if (out1 !== e.i) begin errors++; $display("FAIL basic out1: got %h want %h", out1, e.i); end
   endtask

   task automatic test_delay_zero_nan();
      int g; exp_t e;
      stim = '{32'h0000_0000, 32'h7FC0_0001, 32'h8000_0000};
      do_run(3, 3, g);
      e = exp_q.pop_front();
      checks++; if (g !== e.edge_n) begin errors++; $display("FAIL delay done_edge: got %0d want %0d", g, e.edge_n); end
      checks++; if (out0 !== e.v) begin errors++; $display("FAIL delay out0: got %h want %h", out0, e.v); end
      checks++; if (out1 !== e.i) begin errors++; $display("FAIL delay out1: got %h want %h", out1, e.i); end
   endtask

   task automatic test_edge_lengths();
      int g; exp_t e;
      stim = '{};
      do_run(2, 0, g);
      e = exp_q.pop_front();
      checks++; if (g !== e.edge_n) begin errors++; $display("FAIL len0 done_edge: got %0d want %0d", g, e.edge_n); end
      checks++; if (out0 !== e.v) begin errors++; $display("FAIL len0 out0: got %h want %h", out0, e.v); end
      checks++; if (out1 !== e.i) begin errors++; $display("FAIL len0 out1: got %h want %h", out1, e.i); end
      stim = '{32'h7FC0_0000, 32'hFFFF_FFFF};
      do_run(0, 2, g);
      e = exp_q.pop_front();
      checks++; if (g !== e.edge_n) begin errors++; $display("FAIL allnan done_edge: got %0d want %0d", g, e.edge_n); end
      checks++; if (out0 !== e.v) begin errors++; $display("FAIL allnan out0: got %h want %h", out0, e.v); end
      checks++; if (out1 !== e.i) begin errors++; $display("FAIL allnan out1: got %h want %h", out1, e.i); end
   endtask

   task automatic test_inf_denorm();
      int g; exp_t e;
      stim = '{32'h0000_0001, 32'hFF80_0000, 32'h8000_0001};
      do_run(0, 3, g);
      e = exp_q.pop_front();
      checks++; if (g !== e.edge_n) begin errors++; $display("FAIL infden done_edge: got %0d want %0d", g, e.edge_n); end
      checks++; if (out0 !== e.v) begin errors++; $display("FAIL infden out0: got %h want %h", out0, e.v); end
      checks++; if (out1 !== e.i) begin errors++; $display("FAIL infden out1: got %h want %h", out1, e.i); end
   endtask

   task automatic test_back_to_back();
      int g; exp_t e; int dly; int len;
      for (int r = 0; r < 4; r++) begin
         dly = $urandom_range(0, 2);
         len = $urandom_range(1, 7);
         stim = '{};
         for (int k = 0; k < len; k++) begin
            case ($urandom_range(0, 3))
               0: stim.push_back(32'h7FC0_1234);
               1: stim.push_back({$urandom_range(0, 1) == 1, 8'h81, 23'd0});
               default: stim.push_back($urandom & 32'hBFFF_FFFF);
            endcase
         end
         do_run(dly, len, g);
         e = exp_q.pop_front();
         checks++; if (g !== e.edge_n) begin errors++; $display("FAIL b2b%0d done_edge: got %0d want %0d", r, g, e.edge_n); end
         checks++; if (out0 !== e.v) begin errors++; $display("FAIL b2b%0d out0: got %h want %h", r, out0, e.v); end
         checks++; if (out1 !== e.i) begin errors++; $display("FAIL b2b%0d out1: got %h want %h", r, out1, e.i); end
      end
   endtask

   task automatic test_abort();
      int g; exp_t e;
      stim = '{32'h40A0_0000, 32'h3F80_0000, 32'hBF80_0000, 32'hC000_0000, 32'hC040_0000};
      start_partial(1, 5, 2);
      exp_q.push_back(model(2, 1, 5));
      running = 1'b0; in0 = stim[2];
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort done: got %b want 0", done); end
      checks++; if (out0 !== e.v) begin errors++; $display("FAIL abort out0: got %h want %h", out0, e.v); end
      checks++; if (out1 !== e.i) begin errors++; $display("FAIL abort out1: got %h want %h", out1, e.i); end
      in0 = stim[3];
      repeat (3) @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_hold done: got %b want 0", done); end
      checks++; if (out0 !== e.v) begin errors++; $display("FAIL abort_hold out0: got %h want %h", out0, e.v); end
      running = 1'b1;
      stim = '{32'h4120_0000, 32'h4110_0000, 32'h4130_0000};
      do_run(1, 3, g);
      e = exp_q.pop_front();
      checks++; if (g !== e.edge_n) begin errors++; $display("FAIL post_abort done_edge: got %0d want %0d", g, e.edge_n); end
      checks++; if (out0 !== e.v) begin errors++; $display("FAIL post_abort out0: got %h want %h", out0, e.v); end
      checks++; if (out1 !== e.i) begin errors++; $display("FAIL post_abort out1: got %h want %h", out1, e.i); end
   endtask

   task automatic test_restart();
      int g; exp_t e;
      stim = '{32'hC2C8_0000, 32'hC248_0000};
      start_partial(0, 4, 2);
      stim = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000};
      do_run(1, 3, g);
      e = exp_q.pop_front();
      checks++; if (g !== e.edge_n) begin errors++; $display("FAIL restart done_edge: got %0d want %0d", g, e.edge_n); end
      checks++; if (out0 !== e.v) begin errors++; $display("FAIL restart out0: got %h want %h", out0, e.v); end
      checks++; if (out1 !== e.i) begin errors++; $display("FAIL restart out1: got %h want %h", out1, e.i); end
   endtask

   task automatic test_async_reset();
      int g; exp_t e;
      stim = '{32'h4040_0000, 32'h3F80_0000};
      start_partial(0, 5, 2);
      checks++; if (out0 !== 32'h3F80_0000) begin errors++; $display("FAIL pre_reset out0: got %h want %h", out0, 32'h3F80_0000); end
      #2 rst = 1'b1;
      #1;
      checks++; if (out0 !== 32'h0) begin errors++; $display("FAIL areset out0: got %h want %h", out0, 32'h0); end
      checks++; if (out1 !== 16'h0) begin errors++; $display("FAIL areset out1: got %h want %h", out1, 16'h0); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset done: got %b want 0", done); end
      @(negedge clk);
      rst = 1'b0;
      stim = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
      do_run(0, 3, g);
      e = exp_q.pop_front();
      checks++; if (g !== e.edge_n) begin errors++; $display("FAIL post_reset done_edge: got %0d want %0d", g, e.edge_n); end
      checks++; if (out0 !== e.v) begin errors++; $display("FAIL post_reset out0: got %h want %h", out0, e.v); end
      checks++; if (out1 !== e.i) begin errors++; $display("FAIL post_reset out1: got %h want %h", out1, e.i); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_delay_zero_nan();
      test_edge_lengths();
      test_inf_denorm();
      test_back_to_back();
      test_abort();
      test_restart();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
